// File: rtl/mem_lsu_pkg.sv
// Shared types, funct3 encodings and access-size helpers for the MEM-stage load/store unit.
package mem_lsu_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } lsu_state_t;

   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
      logic res;
      case (size)
         2'b01:   res = off[0];
         2'b10:   res = (off != 2'b00);
         default: res = 1'b0;
      endcase
      return res;
   endfunction

   function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
      logic [3:0] res;
      case (size)
         2'b00:   res = 4'b0001 << off;
         2'b01:   res = 4'b0011 << off;
         default: res = 4'b1111;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Data-memory request/grant/response bus between the LSU (master) and memory (slave).
interface mem_lsu_if;
   logic        dmem_req_o;
   logic        dmem_we_o;
   logic [31:0] dmem_addr_o;
   logic [3:0]  dmem_be_o;
   logic [31:0] dmem_wdata_o;
   logic        dmem_gnt_i;
   logic        dmem_rvalid_i;
   logic [31:0] dmem_rdata_i;

   modport master (
      output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
      input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
   );

   modport slave (
      input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
      output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
   );
endinterface

// File: rtl/mem_lsu_load_ext.sv
// Lane shift of the response word followed by sign/zero extension per load type.
module mem_lsu_load_ext
   import mem_lsu_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  off,
   input  logic [2:0]  funct3,
   output logic [31:0] data
);

   logic [31:0] shifted_s;

   // Shift the addressed byte to lane 0, then extend.
   always_comb begin
      shifted_s = rdata >> {off, 3'b000};
      case (funct3)
         F3_LB:   data = {{24{shifted_s[7]}}, shifted_s[7:0]};
         F3_LH:   data = {{16{shifted_s[15]}}, shifted_s[15:0]};
         F3_LBU:  data = {24'h000000, shifted_s[7:0]};
         F3_LHU:  data = {16'h0000, shifted_s[15:0]};
         default: data = shifted_s;
      endcase
   end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: runs the data-memory handshake, stalls the pipe until
// the access completes, and reports misalignment and response timeouts.
module mem_lsu
   import mem_lsu_pkg::*;
#(
   parameter int RSP_TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             instr_valid_i,
   input  logic             mem_re_i,
   input  logic             mem_we_i,
   input  logic [2:0]       funct3_i,
   input  logic [31:0]      addr_i,
   input  logic [31:0]      wdata_i,
   mem_lsu_if.master        dmem,
   output logic [31:0]      load_data_o,
   output logic             lsu_stall_o,
   output logic             misalign_o,
   output logic             bus_err_o
);

   localparam logic [7:0] TIMEOUT_C = 8'(RSP_TIMEOUT);

   lsu_state_t  state_r;
   logic [7:0]  cnt_r;
   logic [31:0] addr_r;
   logic [3:0]  be_r;
   logic [31:0] wdata_r;
   logic        we_r;
   logic [2:0]  f3_r;
   logic [1:0]  off_r;
   logic [31:0] load_data_r;

   logic        new_s, mis_s, go_s, timeout_s;
   logic [3:0]  be_s;
   logic [31:0] wdata_s, ext_s;
   logic        req_s, we_s;
   logic [31:0] addr_s, bus_wdata_s;
   logic [3:0]  bus_be_s;

   mem_lsu_load_ext u_ext (
      .rdata  (dmem.dmem_rdata_i),
      .off    (off_r),
      .funct3 (f3_r),
      .data   (ext_s)
   );

   // Decode the incoming op: lane placement, byte enables and alignment.
   always_comb begin
      new_s     = (state_r == IDLE) && instr_valid_i && (mem_re_i || mem_we_i);
      mis_s     = misaligned(funct3_i[1:0], addr_i[1:0]);
      go_s      = new_s && !mis_s;
      be_s      = byte_en(funct3_i[1:0], addr_i[1:0]);
      timeout_s = (cnt_r == TIMEOUT_C);
      case (funct3_i[1:0])
         2'b00:   wdata_s = {4{wdata_i[7:0]}};
         2'b01:   wdata_s = {2{wdata_i[15:0]}};
         default: wdata_s = wdata_i;
      endcase
   end

   // Bus drive, stall and status outputs; IDLE forwards the live op, later states replay captured fields.
   always_comb begin
      req_s       = 1'b0;
      we_s        = we_r;
      addr_s      = addr_r;
      bus_be_s    = be_r;
      bus_wdata_s = wdata_r;
      lsu_stall_o = 1'b0;
      misalign_o  = 1'b0;
      bus_err_o   = 1'b0;
      load_data_o = load_data_r;
      case (state_r)
         IDLE: begin
            req_s       = go_s;
            we_s        = mem_we_i;
            addr_s      = {addr_i[31:2], 2'b00};
            bus_be_s    = be_s;
            bus_wdata_s = wdata_s;
            lsu_stall_o = go_s && !(dmem.dmem_gnt_i && mem_we_i);
            misalign_o  = new_s && mis_s;
         end
         REQ: begin
            req_s       = 1'b1;
            lsu_stall_o = dmem.dmem_gnt_i ? !we_r : !timeout_s;
            bus_err_o   = !dmem.dmem_gnt_i && timeout_s;
         end
         WAIT: begin
            lsu_stall_o = !dmem.dmem_rvalid_i && !timeout_s;
            bus_err_o   = !dmem.dmem_rvalid_i && timeout_s;
            if (dmem.dmem_rvalid_i) begin
               load_data_o = ext_s;
            end else begin
               load_data_o = load_data_r;
            end
         end
         default: begin
            req_s = 1'b0;
         end
      endcase
   end

   assign dmem.dmem_req_o   = req_s;
   assign dmem.dmem_we_o    = we_s;
   assign dmem.dmem_addr_o  = addr_s;
   assign dmem.dmem_be_o    = bus_be_s;
   assign dmem.dmem_wdata_o = bus_wdata_s;

   // Handshake FSM with request capture, response timeout counter and load-result hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         cnt_r       <= 8'd0;
         addr_r      <= 32'd0;
         be_r        <= 4'd0;
         wdata_r     <= 32'd0;
         we_r        <= 1'b0;
         f3_r        <= 3'd0;
         off_r       <= 2'd0;
         load_data_r <= 32'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (go_s) begin
                  addr_r  <= {addr_i[31:2], 2'b00};
                  be_r    <= be_s;
                  wdata_r <= wdata_s;
                  we_r    <= mem_we_i;
                  f3_r    <= funct3_i;
                  off_r   <= addr_i[1:0];
                  cnt_r   <= 8'd0;
                  if (!dmem.dmem_gnt_i) begin
                     state_r <= REQ;
                  end else if (!mem_we_i) begin
                     state_r <= WAIT;
                  end else begin
                     state_r <= IDLE;
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            REQ: begin
               // A same-cycle rvalid is not a response to this request; only gnt counts here.
               if (dmem.dmem_gnt_i) begin
                  state_r <= we_r ? IDLE : WAIT;
                  cnt_r   <= 8'd0;
               end else if (timeout_s) begin
                  state_r <= IDLE;
               end else begin
                  cnt_r <= cnt_r + 8'd1;
               end
            end
            WAIT: begin
               if (dmem.dmem_rvalid_i) begin
                  load_data_r <= ext_s;
                  state_r     <= IDLE;
               end else if (timeout_s) begin
                  state_r <= IDLE;
               end else begin
                  cnt_r <= cnt_r + 8'd1;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Load/store unit in the MEM stage, directly upstream of the MEM/WB pipeline register.
- Takes the EX/MEM memory op, runs a request/grant/response handshake with data memory, and generates byte enables and store-data lane shifting.
- Sign/zero-extends load data onto load_data_o, which feeds load_data_mem_i of MEM/WB.
- Stalls the pipeline until the access completes; flags misalignment and response timeout.

Parameters:
- RSP_TIMEOUT, 255: max cycles in REQ or WAIT before bus_err_o; 8-bit counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- instr_valid_i  in  1  MEM-stage instruction valid
- mem_re_i  in  1  load op
- mem_we_i  in  1  store op; mem_re_i and mem_we_i are never both set
- funct3_i  in  3  access size/sign (RV32I encoding)
- addr_i  in  32  byte address from ALU
- wdata_i  in  32  store data (rs2)
- dmem_req_o  out  1  request valid
- dmem_we_o  out  1  write
- dmem_addr_o  out  32  word-aligned address, {addr[31:2],2'b00}
- dmem_be_o  out  4  byte enables
- dmem_wdata_o  out  32  lane-shifted store data
- dmem_gnt_i  in  1  request accepted
- dmem_rvalid_i  in  1  read data valid
- dmem_rdata_i  in  32  read data
- load_data_o  out  32  extended load result
- lsu_stall_o  out  1  hold IF..MEM stages
- misalign_o  out  1  misaligned access, no bus request issued
- bus_err_o  out  1  one-cycle timeout pulse

Behaviour:
- Reset: state IDLE, timeout counter 0, all captured request fields 0, load_data_o 0.
  - Outputs that are combinational from state are at their IDLE values: dmem_req_o 0, lsu_stall_o 0, misalign_o 0, bus_err_o 0.
- Access is "new" when state==IDLE && instr_valid_i && (mem_re_i|mem_we_i).
- Misalignment check:
  - Halfword (funct3[1:0]==01) with addr[0]==1 is misaligned.
  - Word (funct3[1:0]==10) with addr[1:0]!=0 is misaligned.
  - On a misaligned new access: misalign_o=1 (combinational), no request, no stall, state stays IDLE.
- Byte enables and store lanes:
  - Byte: be=4'b0001<<addr[1:0], wdata={4{wdata_i[7:0]}}.
  - Half: be=4'b0011<<addr[1:0], wdata={2{wdata_i[15:0]}}.
  - Word: be=4'b1111, wdata=wdata_i.
  - Loads drive be the same way; dmem_we_o=0.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - On a valid new access, drive the request combinationally from inputs and capture all request fields into registers.
  - gnt && store: done, stay IDLE, stall 0.
  - gnt && load: go to WAIT, stall 1.
  - !gnt: go to REQ, stall 1.
- REQ:
  - Drive the request from captured registers; it must stay stable until gnt and is never retracted.
  - On gnt: store goes to IDLE with stall 0 that cycle; load goes to WAIT.
- WAIT:
  - dmem_req_o=0; stall 1 until dmem_rvalid_i.
  - In the rvalid cycle: stall 0, load_data_o=extend(rdata), go to IDLE.
- Extension:
  - Byte = rdata>>(8*addr[1:0]).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- load_data_o hold: outside the rvalid cycle, load_data_o holds the last extended value from a register updated on rvalid.
- rvalid while in IDLE or REQ: ignored.
- gnt and rvalid in the same cycle while in IDLE or REQ: only gnt is honoured; the response is expected on a later cycle.
- Timeout:
  - Counter clears on entry to REQ/WAIT and increments each cycle there.
  - When it reaches RSP_TIMEOUT: bus_err_o=1 for one cycle, stall 0, state to IDLE, load_data_o unchanged.
- Reset mid-operation: state returns to IDLE immediately; any pending request is abandoned.

Decomposition:
- Into include/defines.svh:
  - funct3 constants: LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101.
  - LSU state enum lsu_state_t {IDLE,REQ,WAIT}.
- One sub-module is natural: lsu_load_ext, combinational shift and sign/zero extension.

Test Plan:
- SW addr=0x100 wdata=0xDEADBEEF, gnt same cycle -> req=1, be=1111, addr=0x100, we=1; stall 0; state IDLE.
- SB addr=0x103 wdata=0x000000A5 -> be=1000, dmem_wdata=0xA5A5A5A5.
- LB addr=0x102, gnt cycle 0, rvalid cycle 2 with rdata=0x12F03456 -> stall high for cycle 0 and cycle 1 only; stall 0 in cycle 2; load_data_o=0xFFFFFFF0.
  - LBU with the same stimulus -> 0x000000F0.
- LH addr=0x101 -> misalign_o=1, req=0, stall=0.
  - LW addr=0x102 -> misalign_o=1.
- LW with gnt withheld 3 cycles -> addr, be, we stable over all 4 request cycles.
  - Then rdata=0xCAFEF00D -> load_data_o=0xCAFEF00D.
- LW granted, no rvalid for RSP_TIMEOUT cycles -> bus_err_o one pulse, stall drops, FSM IDLE.
  - Separate run: assert rst_n low in WAIT -> IDLE, stall 0, load_data_o 0.
